mem_bus_arbiter: RTL and testbench

- Shares the core's single memory bus master port between the IFU (instruction fetch, read-only) and the LSU (load/store).
- Sits between the fetch/LSU stages and the bus bridge.
- Allows one outstanding transaction at a time. The LSU has priority, and an anti-starvation counter protects the IFU.
- Supports a pipeline flush that drops in-flight fetch responses, and a configurable response timeout that returns an error.

---
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus master port between IFU fetches and LSU accesses. Only one transaction is in flight at a time.
// The request reaches the bus the cycle after grant and the response pulses the cycle after bus acceptance. Requesters see ready=0 while the port is busy.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,

    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_req_ready,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wstrb,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_rdata,
    output logic        lsu_resp_err,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_resp_valid,
    output logic        bus_resp_ready,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err,

    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [1:0]  OWN_NONE    = 2'b00;
    localparam logic [1:0]  OWN_IFU     = 2'b01;
    localparam logic [1:0]  OWN_LSU     = 2'b10;
    localparam logic [3:0]  STREAK_MAX  = 4'(STARVE_LIMIT);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    req_t        req_q;
    logic [3:0]  streak;
    logic        drop;
    logic [31:0] timer;

    logic        grant_ifu;
    logic        grant_lsu;
    logic        resp_fire;
    logic        timeout_fire;
    logic        txn_end;

    always_comb begin
        state_nxt    = state;
        grant_ifu    = 1'b0;
        grant_lsu    = 1'b0;
        resp_fire    = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                // LSU wins contention unless the IFU has waited out the streak; flush vetoes any fetch grant
                if (!reset) begin
                    grant_ifu = ifu_req_valid && !flush &&
                                (!lsu_req_valid || (streak == STREAK_MAX));
                    grant_lsu = lsu_req_valid && !grant_ifu;
                end
                if (grant_ifu || grant_lsu) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_fire    = bus_resp_valid;
                timeout_fire = (TIMEOUT != 0) && !bus_resp_valid && (timer == TIMEOUT_CYC);
                if (resp_fire || timeout_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign txn_end = resp_fire || timeout_fire;

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign bus_req_valid  = (state == REQ);
    assign bus_req_addr   = (state == REQ) ? req_q.addr  : 32'd0;
    assign bus_req_wen    = (state == REQ) ? req_q.wen   : 1'b0;
    assign bus_req_wdata  = (state == REQ) ? req_q.wdata : 32'd0;
    assign bus_req_wstrb  = (state == REQ) ? req_q.wstrb : 4'd0;
    assign bus_resp_ready = (state == RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= OWN_NONE;
            streak         <= 4'd0;
            drop           <= 1'b0;
            timer          <= 32'd0;
            req_q          <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= 32'd0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_rdata <= 32'd0;
            lsu_resp_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (grant_ifu) begin
                owner  <= OWN_IFU;
                streak <= 4'd0;
                req_q  <= '{addr: ifu_req_addr, wen: 1'b0, wdata: 32'd0, wstrb: 4'd0};
            end else if (grant_lsu) begin
                owner <= OWN_LSU;
                req_q <= '{addr: lsu_req_addr, wen: lsu_req_wen,
                           wdata: lsu_req_wdata, wstrb: lsu_req_wstrb};
                if (!ifu_req_valid) begin
                    streak <= 4'd0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end

            if ((TIMEOUT != 0) && (state == RESP) && !txn_end) begin
                timer <= timer + 32'd1;
            end else begin
                timer <= 32'd0;
            end

            // A flushed fetch still runs to completion on the bus; only its response is swallowed
            if (flush && (owner == OWN_IFU) && (state != IDLE)) begin
                drop <= 1'b1;
            end

            if (txn_end) begin
                drop  <= 1'b0;
                owner <= OWN_NONE;
                if (owner == OWN_LSU) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_resp_rdata <= resp_fire ? bus_resp_rdata : 32'd0;
                    lsu_resp_err   <= resp_fire ? bus_resp_err : 1'b1;
                end else if ((owner == OWN_IFU) && !drop && !flush) begin
                    ifu_resp_valid <= 1'b1;
                    ifu_resp_data  <= resp_fire ? bus_resp_rdata : 32'd0;
                    ifu_resp_err   <= resp_fire ? bus_resp_err : 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with STARVE_LIMIT=4 and TIMEOUT=8.
// Inputs change 1ns after the rising edge and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        lsu_resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_wen;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;
    logic [1:0]  owner;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
        .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
        .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err),
        .owner(owner)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        flush          = 1'b0;
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = 32'd0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = 32'd0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = 32'd0;
        lsu_req_wstrb  = 4'd0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'd0;
        bus_resp_err   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready});
        end
        tests_run++;
        if ({owner, bus_req_valid, bus_resp_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_owner_bus: got %b expected 0000", {owner, bus_req_valid, bus_resp_ready});
        end
        tests_run++;
        if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_resp: got %b expected 0000",
                     {ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err});
        end
        tests_run++;
        if ({ifu_resp_data, lsu_resp_rdata, bus_req_addr, bus_req_wdata} !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     ifu_resp_data, lsu_resp_rdata, bus_req_addr, bus_req_wdata);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_lsu_read;
        logic ifu_seen;
        ifu_seen = 1'b0;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'd0; lsu_req_wstrb = 4'hF; bus_req_ready = 1'b1;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready, bus_req_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL lsu_read_grant: got %b expected 010", {ifu_req_ready, lsu_req_ready, bus_req_valid});
        end
        tick();
        lsu_req_valid = 1'b0;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({bus_req_valid, bus_req_wen, owner, bus_req_addr} !== {1'b1, 1'b0, 2'b10, 32'h8000_0010}) begin
            tests_failed++;
            $display("FAIL lsu_read_busreq: got v=%b wen=%b own=%b addr=%h expected 1 0 10 80000010",
                     bus_req_valid, bus_req_wen, owner, bus_req_addr);
        end
        tick();
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({bus_req_valid, bus_resp_ready, lsu_resp_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL lsu_read_resp_wait: got %b expected 010", {bus_req_valid, bus_resp_ready, lsu_resp_valid});
        end
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hDEAD_BEEF; bus_resp_err = 1'b0;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tick();
        bus_resp_valid = 1'b0; bus_resp_rdata = 32'd0;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({lsu_resp_valid, lsu_resp_err, owner, lsu_resp_rdata} !== {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL lsu_read_pulse: got v=%b err=%b own=%b data=%h expected 1 0 00 deadbeef",
                     lsu_resp_valid, lsu_resp_err, owner, lsu_resp_rdata);
        end
        tick();
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({lsu_resp_valid, ifu_seen} !== 2'b00) begin
            tests_failed++;
            $display("FAIL lsu_read_single_pulse: got lsu_v=%b ifu_seen=%b expected 0 0", lsu_resp_valid, ifu_seen);
        end
    endtask

    task automatic test_starvation;
        logic [9:0] got;
        int         n;
        logic       pend_ifu;
        got = 10'd0; n = 0; pend_ifu = 1'b0;
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_2000; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'hA5A5_A5A5; lsu_req_wstrb = 4'hF;
        bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0000_0013;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clock);
            if (pend_ifu) begin
                tests_run++;
                if ({bus_req_valid, bus_req_wen, bus_req_wstrb, bus_req_addr} !== {1'b1, 1'b0, 4'h0, 32'h0000_1000}) begin
                    tests_failed++;
                    $display("FAIL starve_ifu_fields: got v=%b wen=%b strb=%h addr=%h expected 1 0 0 00001000",
                             bus_req_valid, bus_req_wen, bus_req_wstrb, bus_req_addr);
                end
                pend_ifu = 1'b0;
            end
            if (ifu_req_ready) begin
                got[n] = 1'b1; n++; pend_ifu = 1'b1;
            end else if (lsu_req_ready) begin
                got[n] = 1'b0; n++;
            end
            tick();
        end
        @(negedge clock);
        if (pend_ifu) begin
            tests_run++;
            if ({bus_req_valid, bus_req_wen, bus_req_wstrb} !== {1'b1, 1'b0, 4'h0}) begin
                tests_failed++;
                $display("FAIL starve_ifu_fields_last: got v=%b wen=%b strb=%h expected 1 0 0",
                         bus_req_valid, bus_req_wen, bus_req_wstrb);
            end
        end
        tests_run++;
        if (n !== 10 || got !== 10'b10_0001_0000) begin
            tests_failed++;
            $display("FAIL starve_order: got %0d grants pattern %b expected 10 grants pattern 1000010000", n, got);
        end
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush;
        logic ifu_seen;
        ifu_seen = 1'b0;
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; flush = 1'b1; bus_req_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ifu_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_blocks_grant: got ready=%b expected 0", ifu_req_ready);
        end
        tick();
        flush = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ifu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ifu_grant: got ready=%b expected 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({bus_req_valid, bus_req_wstrb, owner, bus_req_addr} !== {1'b1, 4'h0, 2'b01, 32'h8000_0000}) begin
            tests_failed++;
            $display("FAIL flush_ifu_busreq: got v=%b strb=%h own=%b addr=%h expected 1 0 01 80000000",
                     bus_req_valid, bus_req_wstrb, owner, bus_req_addr);
        end
        tick();
        flush = 1'b1;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tick();
        flush = 1'b0;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0000_0013;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tick();
        bus_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
        @(negedge clock);
        ifu_seen |= ifu_resp_valid;
        tests_run++;
        if ({ifu_seen, ifu_req_ready, owner} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL flush_dropped_regrant: got seen=%b ready=%b own=%b expected 0 1 00",
                     ifu_seen, ifu_req_ready, owner);
        end
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h8000_0004}) begin
            tests_failed++;
            $display("FAIL flush_next_busreq: got v=%b addr=%h expected 1 80000004", bus_req_valid, bus_req_addr);
        end
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0000_0093; bus_resp_err = 1'b1;
        tick();
        bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_resp_data} !== {3'b110, 32'h0000_0093}) begin
            tests_failed++;
            $display("FAIL flush_next_resp: got v=%b err=%b lsu_v=%b data=%h expected 1 1 0 00000093",
                     ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_resp_data);
        end
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0000_0001; flush = 1'b1;
        tick();
        bus_resp_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({ifu_resp_valid, owner} !== 3'b000) begin
            tests_failed++;
            $display("FAIL flush_at_resp: got v=%b own=%b expected 0 00", ifu_resp_valid, owner);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure;
        int hs;
        hs = 0;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0100; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wstrb = 4'b0011; bus_req_ready = 1'b0;
        @(negedge clock);
        tests_run++;
        if (lsu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_grant: got ready=%b expected 1", lsu_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_3000;
            @(negedge clock);
            if (bus_req_valid && bus_req_ready) hs++;
            tests_run++;
            if ({bus_req_valid, bus_req_wen, bus_req_wstrb, ifu_req_ready, lsu_req_ready,
                 bus_req_addr, bus_req_wdata} !== {1'b1, 1'b1, 4'b0011, 2'b00, 32'h0000_0100, 32'h1234_5678}) begin
                tests_failed++;
                $display("FAIL bp_stable cycle %0d: got v=%b wen=%b strb=%b rdy=%b%b addr=%h wdata=%h expected 1 1 0011 00 00000100 12345678",
                         k, bus_req_valid, bus_req_wen, bus_req_wstrb, ifu_req_ready, lsu_req_ready,
                         bus_req_addr, bus_req_wdata);
            end
        end
        tick();
        bus_req_ready = 1'b1;
        @(negedge clock);
        if (bus_req_valid && bus_req_ready) hs++;
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        if (bus_req_valid && bus_req_ready) hs++;
        tick();
        bus_resp_valid = 1'b0; bus_req_ready = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({lsu_resp_valid, lsu_resp_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL bp_resp: got v=%b data=%h expected 1 cafef00d", lsu_resp_valid, lsu_resp_rdata);
        end
        tests_run++;
        if (hs !== 1) begin
            tests_failed++;
            $display("FAIL bp_handshakes: got %0d expected 1", hs);
        end
        tests_run++;
        if (ifu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_held_ifu_grant: got ready=%b expected 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0; bus_req_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h0000_3000}) begin
            tests_failed++;
            $display("FAIL bp_held_ifu_busreq: got v=%b addr=%h expected 1 00003000", bus_req_valid, bus_req_addr);
        end
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'd0;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout;
        int pulse_at;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_at = -1;
            tick();
            lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0040; lsu_req_wen = 1'b0;
            lsu_req_wstrb = 4'hF; bus_req_ready = 1'b1;
            tick();
            lsu_req_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                bus_resp_valid = (pass == 1) && (k == 8);
                bus_resp_rdata = (pass == 1) && (k == 8) ? 32'h55AA_55AA : 32'd0;
                @(negedge clock);
                if (lsu_resp_valid && pulse_at < 0) pulse_at = k;
            end
            tests_run++;
            if (pulse_at !== 9) begin
                tests_failed++;
                $display("FAIL timeout_pulse_cycle pass %0d: got %0d expected 9", pass, pulse_at);
            end
            tests_run++;
            if (pass == 0 && {lsu_resp_valid, lsu_resp_err, owner, lsu_resp_rdata} !== {4'b1100, 32'd0}) begin
                tests_failed++;
                $display("FAIL timeout_err_resp: got v=%b err=%b own=%b data=%h expected 1 1 00 00000000",
                         lsu_resp_valid, lsu_resp_err, owner, lsu_resp_rdata);
            end else if (pass == 1 && {lsu_resp_valid, lsu_resp_err, lsu_resp_rdata} !== {2'b10, 32'h55AA_55AA}) begin
                tests_failed++;
                $display("FAIL timeout_late_ok: got v=%b err=%b data=%h expected 1 0 55aa55aa",
                         lsu_resp_valid, lsu_resp_err, lsu_resp_rdata);
            end
            idle_inputs();
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        seen = 1'b0;
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_5000; bus_req_ready = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ifu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_grant: got ready=%b expected 1", ifu_req_ready);
        end
        tick();
        lsu_req_valid = 1'b1; reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({bus_req_valid, owner} !== 3'b101) begin
            tests_failed++;
            $display("FAIL rstmid_in_req: got v=%b own=%b expected 1 01", bus_req_valid, owner);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({owner, bus_req_valid, ifu_req_ready, lsu_req_ready} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL rstmid_cleared: got own=%b v=%b rdy=%b%b expected 00 0 00",
                     owner, bus_req_valid, ifu_req_ready, lsu_req_ready);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            seen |= ifu_resp_valid | lsu_resp_valid | bus_resp_ready;
            tick();
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_pulse: got %b expected 0", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lsu_read();
        test_starvation();
        test_flush();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
